// File: rtl/alu_exec_seq.sv
// alu_exec_seq -- execute-stage ALU with registered result.
//   Decodes ALUOp/funct3/funct7 into a 4-bit ALU control and executes the op.
//   Base ops finish in one cycle. RV32M MUL*/DIV*/REM* ops run on an iterative
//   one-bit-per-cycle engine (shift-add multiply / restoring divide) and hold
//   ready_o low while they run.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   valid_i / ready_o        request handshake; accept = valid_i & ready_o
//   ALUOp, funct3, funct7_5, funct7_0, op5   decode inputs
//   src_a, src_b             operands, sampled only on accept
//   result_o, zero_o         registered result and (result_o == 0)
//   ALUControl               registered control of the last accepted op
//   result_valid             one-cycle pulse when result_o/zero_o/ALUControl are valid
//   illegal_o                pulses with result_valid for an M op when ENABLE_M = 0
module alu_exec_seq #(
    parameter int WIDTH    = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             funct7_0,
    input  logic             op5,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [3:0]       ALUControl,
    output logic             result_valid,
    output logic             illegal_o
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_AND  = 4'b0010;
    localparam logic [3:0] C_OR   = 4'b0011;
    localparam logic [3:0] C_XOR  = 4'b0100;
    localparam logic [3:0] C_SLT  = 4'b0101;
    localparam logic [3:0] C_SLL  = 4'b0110;
    localparam logic [3:0] C_SRL  = 4'b0111;
    localparam logic [3:0] C_JAL  = 4'b1000;
    localparam logic [3:0] C_SRA  = 4'b1001;
    localparam logic [3:0] C_SLTU = 4'b1010;
    localparam logic [3:0] C_MUL  = 4'b1011;
    localparam logic [3:0] C_DIV  = 4'b1100;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_CALC} state_t;

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_res;
    logic                 r_zero, r_vld, r_ill;
    logic [3:0]           r_ctrl;
    // Engine: r_prod holds {hi, lo}. Multiply: hi = partial sum, lo = multiplier.
    // Divide: hi = partial remainder, lo = dividend shifting into quotient.
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_opnd;     // multiplicand or divisor magnitude
    logic [SW-1:0]        r_cnt;
    logic                 r_is_div, r_sel, r_negq, r_negr;

    logic                 w_acc, w_is_m, w_special, w_start, w_b_zero, w_ovf;
    logic [3:0]           w_ctrl;
    logic [WIDTH-1:0]     w_base, w_spec_res;
    logic [SW-1:0]        w_shamt;
    logic                 w_a_sgn, w_b_sgn, w_sa, w_sb;
    logic [WIDTH-1:0]     w_ma, w_mb;
    logic [WIDTH:0]       w_sum, w_sh, w_diff;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt, w_step, w_full;
    logic [WIDTH-1:0]     w_q, w_r, w_mres, w_dres;
    logic                 w_load, w_ill;
    logic [WIDTH-1:0]     w_res;

    assign ready_o      = (r_state == S_IDLE);
    assign w_acc        = valid_i & ready_o;
    assign result_o     = r_res;
    assign zero_o       = r_zero;
    assign ALUControl   = r_ctrl;
    assign result_valid = r_vld;
    assign illegal_o    = r_ill;

    assign w_shamt = src_b[SW-1:0];
    assign w_is_m  = (ALUOp == 2'b10) && op5 && funct7_0 && !funct7_5;

    // Decode: the M group takes priority over the base funct3 decode.
    always_comb begin
        w_ctrl = C_ADD;
        case (ALUOp)
            2'b00: w_ctrl = C_ADD;
            2'b01: w_ctrl = C_SUB;
            2'b11: w_ctrl = C_JAL;
            default: begin
                if (w_is_m) begin
                    w_ctrl = funct3[2] ? C_DIV : C_MUL;
                end else begin
                    case (funct3)
                        3'b000:  w_ctrl = (op5 && funct7_5) ? C_SUB : C_ADD;
                        3'b001:  w_ctrl = C_SLL;
                        3'b010:  w_ctrl = C_SLT;
                        3'b011:  w_ctrl = C_SLTU;
                        3'b100:  w_ctrl = C_XOR;
                        3'b101:  w_ctrl = funct7_5 ? C_SRA : C_SRL;
                        3'b110:  w_ctrl = C_OR;
                        default: w_ctrl = C_AND;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        w_base = '0;
        case (w_ctrl)
            C_ADD:   w_base = src_a + src_b;
            C_SUB:   w_base = src_a - src_b;
            C_AND:   w_base = src_a & src_b;
            C_OR:    w_base = src_a | src_b;
            C_XOR:   w_base = src_a ^ src_b;
            C_SLT:   w_base = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            C_SLTU:  w_base = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            C_SLL:   w_base = src_a << w_shamt;
            C_SRL:   w_base = src_a >> w_shamt;
            C_SRA:   w_base = $signed(src_a) >>> w_shamt;
            C_JAL:   w_base = src_a + WIDTH'(4);
            default: w_base = '0;
        endcase
    end

    // Division corner cases resolve in one cycle without entering CALC.
    // funct3[0] = 0 marks the signed DIV/REM, funct3[1] = 1 marks REM/REMU.
    assign w_b_zero   = (src_b == '0);
    assign w_ovf      = !funct3[0] && (src_a == MIN_VAL) && (src_b == '1);
    assign w_special  = funct3[2] && (w_b_zero || w_ovf);
    assign w_spec_res = w_b_zero ? (funct3[1] ? src_a : '1)
                                 : (funct3[1] ? '0 : MIN_VAL);
    assign w_start    = w_acc && w_is_m && ENABLE_M && !w_special;

    // Operand signedness: MUL/MULH signed x signed, MULHSU signed x unsigned,
    // MULHU unsigned; DIV/REM signed, DIVU/REMU unsigned.
    always_comb begin
        if (funct3[2]) begin
            w_a_sgn = !funct3[0];
            w_b_sgn = !funct3[0];
        end else begin
            w_a_sgn = (funct3[1:0] != 2'b11);
            w_b_sgn = !funct3[1];
        end
    end
    assign w_sa = w_a_sgn && src_a[WIDTH-1];
    assign w_sb = w_b_sgn && src_b[WIDTH-1];
    assign w_ma = w_sa ? -src_a : src_a;
    assign w_mb = w_sb ? -src_b : src_b;

    // One multiply step: conditionally add multiplicand to the high half, shift right.
    assign w_sum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_opnd : '0)};
    assign w_mul_nxt = {w_sum, r_prod[WIDTH-1:1]};
    // One restoring-divide step: shift in next dividend bit, subtract if no borrow.
    assign w_sh      = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_diff    = w_sh - {1'b0, r_opnd};
    assign w_ge      = !w_diff[WIDTH];
    assign w_div_nxt = {(w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0]), r_prod[WIDTH-2:0], w_ge};
    assign w_step    = r_is_div ? w_div_nxt : w_mul_nxt;

    // Sign fix-up on the final step's value, applied as result_o is loaded.
    assign w_full = r_negq ? -w_step : w_step;
    assign w_mres = r_sel ? w_full[2*WIDTH-1:WIDTH] : w_full[WIDTH-1:0];
    assign w_q    = w_step[WIDTH-1:0];
    assign w_r    = w_step[2*WIDTH-1:WIDTH];
    assign w_dres = r_sel ? (r_negr ? -w_r : w_r) : (r_negq ? -w_q : w_q);

    always_comb begin
        w_load = 1'b0;
        w_ill  = 1'b0;
        w_res  = '0;
        if (r_state == S_CALC) begin
            if (r_cnt == '0) begin
                w_load = 1'b1;
                w_res  = r_is_div ? w_dres : w_mres;
            end
        end else if (w_acc && !w_start) begin
            w_load = 1'b1;
            if (w_is_m && !ENABLE_M) begin
                w_ill = 1'b1;
            end else if (w_is_m) begin
                w_res = w_spec_res;
            end else begin
                w_res = w_base;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res    <= '0;
            r_zero   <= 1'b0;
            r_vld    <= 1'b0;
            r_ill    <= 1'b0;
            r_ctrl   <= '0;
            r_prod   <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sel    <= 1'b0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
        end else begin
            r_vld <= w_load;
            r_ill <= w_load && w_ill;
            if (w_load) begin
                r_res  <= w_res;
                r_zero <= (w_res == '0);
            end
            if (w_acc) r_ctrl <= w_ctrl;
            if (w_start) begin
                r_is_div <= funct3[2];
                // r_sel: high half for MULH*, remainder for REM*
                r_sel    <= funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
                r_negq   <= w_sa ^ w_sb;
                r_negr   <= w_sa;
                r_prod   <= {{WIDTH{1'b0}}, (funct3[2] ? w_ma : w_mb)};
                r_opnd   <= funct3[2] ? w_mb : w_ma;
                r_cnt    <= SW'(WIDTH - 1);
            end else if (r_state == S_CALC) begin
                r_prod <= w_step;
                r_cnt  <= r_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_seq.sv
module tb_alu_exec_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic        funct7_5, funct7_0, op5;
    logic [31:0] src_a, src_b;
    logic [31:0] result_o;
    logic        zero_o;
    logic [3:0]  ALUControl;
    logic        result_valid;
    logic        illegal_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  ctrl;
        int          lat;
        int          acc;
        string       tag;
    } exp_t;
    exp_t sb[$];

    alu_exec_seq #(.WIDTH(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .op5(op5), .src_a(src_a), .src_b(src_b), .result_o(result_o),
        .zero_o(zero_o), .ALUControl(ALUControl), .result_valid(result_valid),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference for the M group, built from plain 64-bit / int arithmetic.
    function automatic logic [31:0] mref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        logic ovf;
        ea  = (f[1:0] != 2'b11 && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
        eb  = (!f[1] && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
        p   = ea * eb;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f)
            3'd0:    mref = p[31:0];
            3'd1, 3'd2, 3'd3: mref = p[63:32];
            3'd4:    mref = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(sa / sb);
            3'd5:    mref = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6:    mref = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: mref = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int mlat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) mlat = 0;
        else mlat = 32;
    endfunction

    // Wait for ready, present one op for one accept edge, push its expectation.
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                         input logic f70, input logic o5, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic [3:0] ec,
                         input int lat, input bit push, input string tag);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk({tag, "_ready_timeout"}, 32'(ready_o), 32'd1);
        ALUOp = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; op5 = o5;
        src_a = a; src_b = b; valid_i = 1'b1;
        @(posedge clk);
        #1;
        e.res = er; e.ctrl = ec; e.lat = lat; e.acc = cyc; e.tag = tag;
        if (push) sb.push_back(e);
        valid_i = 1'b0;
        // Scramble inputs: the DUT must have sampled them on accept.
        src_a = $urandom; src_b = $urandom; funct3 = 3'($urandom);
    endtask

    task automatic issue_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
        issue(2'b10, f3, 1'b0, 1'b1, 1'b1, a, b, mref(f3, a, b),
              f3[2] ? 4'b1100 : 4'b1011, mlat(f3, a, b), 1'b1, tag);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_res"}, result_o, e.res);
                chk({e.tag, "_ctrl"}, 32'(ALUControl), 32'(e.ctrl));
                chk({e.tag, "_zero"}, 32'(zero_o), 32'(e.res == 32'h0));
                chk({e.tag, "_illegal"}, 32'(illegal_o), 32'd0);
                chk({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; valid_i = 1'b0; ALUOp = 2'b00; funct3 = 3'b000;
        funct7_5 = 1'b0; funct7_0 = 1'b0; op5 = 1'b0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_ctrl", 32'(ALUControl), 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        rst = 1'b0;

        // Base ops
        issue(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b0001, 0, 1, "sub_r");
        issue(2'b00, 3'b111, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 4'b0000, 0, 1, "aluop_add");
        issue(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 4'b0001, 0, 1, "aluop_sub_zero");
        issue(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'h100, 32'd55, 32'h104, 4'b1000, 0, 1, "jal");
        issue(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd10, 32'd1, 32'd11, 4'b0000, 0, 1, "addi_f75");
        issue(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'd4, 32'hF8000000, 4'b1001, 0, 1, "sra");
        issue(2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'd4, 32'h08000000, 4'b0111, 0, 1, "srl");
        issue(2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF, 32'd1, 4'b1010, 0, 1, "sltu");
        issue(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF, 32'd0, 4'b0101, 0, 1, "slt");
        issue(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1, 32'h25, 32'h20, 4'b0110, 0, 1, "sll_shamt");
        issue(2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'h0FF0, 4'b0100, 0, 1, "xor");
        issue(2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'hFFF0, 4'b0011, 0, 1, "or");
        issue(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'hF000, 4'b0010, 0, 1, "and");

        // MULH -1*2: ready_o low for exactly 32 cycles
        issue(2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 4'b1011, 32, 1, "mulh");
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mulh_busy_cycles", 32'(n), 32'd32);

        // DIV / REM and the one-cycle special cases
        issue(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 4'b1100, 32, 1, "div_neg");
        issue(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 4'b1100, 32, 1, "rem_neg");
        issue(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'h1234, 32'd0, 32'hFFFFFFFF, 4'b1100, 0, 1, "divu_by0");
        issue(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'h1234, 32'd0, 32'h1234, 4'b1100, 0, 1, "remu_by0");
        issue(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1100, 0, 1, "div_ovf");
        issue(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 4'b1100, 0, 1, "rem_ovf");

        // valid_i during CALC must be ignored (no extra result)
        issue_m(3'b000, 32'd6, 32'd7, "mul_busy");
        repeat (2) @(negedge clk);
        ALUOp = 2'b00; valid_i = 1'b1;
        repeat (3) @(negedge clk);
        valid_i = 1'b0;

        // Back-to-back M ops through the reference model
        for (int i = 0; i < 10; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'(i % 8);
            a = $urandom;
            b = (i == 9) ? 32'd3 : $urandom;
            issue_m(f, a, b, "m_rand");
        end

        // Reset in CALC aborts the op; the next op runs cleanly
        issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd3, 32'd5, 32'd15, 4'b1011, 32, 0, "mul_abort");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(ready_o), 32'd1);
        chk("abort_no_valid", 32'(result_valid), 32'd0);
        issue_m(3'b000, 32'd3, 32'd5, "mul_after_rst");

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
